address_generator: RTL

- Owns the program counter and drives the 16-bit external address bus.
- After reset, fetches the reset vector from RESET_VECTOR / RESET_VECTOR+1 and loads it into PC. Only then are decode-stage controls honoured.
- In run mode it consumes instruction_decode outputs (pc_enable, address_select, memory_address) plus the ALU result, and produces the address and PC seen by memory and the decoder.

---
 rtl/address_generator_pkg.sv | 16 +
 rtl/address_generator_program_counter.sv | 29 ++
 rtl/address_generator.sv | 89 ++++++++
 3 files changed

// File: rtl/address_generator_pkg.sv
// Address-select codes and vector-fetch state encodings shared by address_generator and instruction_decode.
// Pure declarations: no latency, no flow control.
package address_generator_pkg;

    localparam logic [1:0] ADR_SEL_PC  = 2'd0;
    localparam logic [1:0] ADR_SEL_MEM = 2'd1;
    localparam logic [1:0] ADR_SEL_ALU = 2'd2;
    localparam logic [1:0] ADR_SEL_RSV = 2'd3;

    typedef enum logic [1:0] {
        V_LO  = 2'd0,
        V_HI  = 2'd1,
        V_RUN = 2'd2
    } vec_state_t;

endpackage

// File: rtl/address_generator_program_counter.sv
// 16-bit program counter: load has priority over increment, otherwise hold.
// One-cycle update; rdy=0 freezes the register, res clears it regardless of rdy.
module program_counter (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        i_load,
    input  logic        i_inc,
    input  logic [15:0] i_load_value,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;

    always_ff @(posedge clk) begin
        if (res) begin
            r_pc <= 16'h0000;
        end else if (rdy) begin
            if (i_load) begin
                r_pc <= i_load_value;
            end else if (i_inc) begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/address_generator.sv
// Fetches the reset vector into PC, then drives the address bus from PC / decoder address / zero-page ALU result.
// Vector load takes 2 rdy-qualified cycles after reset; address is combinational; rdy=0 freezes all state.
module address_generator
    import address_generator_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        pc_enable,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    input  logic [1:0]  address_select,
    input  logic [15:0] memory_address,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  data_in,
    output logic [15:0] address,
    output logic [15:0] pc,
    output logic        vector_done
);

    vec_state_t  r_state;
    vec_state_t  w_state_nxt;
    logic        w_pc_load;
    logic        w_pc_inc;
    logic [15:0] w_pc_load_value;
    logic [15:0] w_pc;

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= V_LO;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Vector bytes go through the PC load path, merged with the half already held.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_load       = 1'b0;
        w_pc_inc        = 1'b0;
        w_pc_load_value = pc_load_value;
        address         = w_pc;
        vector_done     = 1'b0;
        case (r_state)
            V_LO: begin
                address         = RESET_VECTOR;
                w_pc_load       = 1'b1;
                w_pc_load_value = {w_pc[15:8], data_in};
                w_state_nxt     = V_HI;
            end
            V_HI: begin
                address         = RESET_VECTOR + 16'd1;
                w_pc_load       = 1'b1;
                w_pc_load_value = {data_in, w_pc[7:0]};
                w_state_nxt     = V_RUN;
            end
            V_RUN: begin
                vector_done = 1'b1;
                w_pc_load   = pc_load;
                w_pc_inc    = pc_enable;
                case (address_select)
                    ADR_SEL_PC:  address = w_pc;
                    ADR_SEL_MEM: address = memory_address;
                    ADR_SEL_ALU: address = {8'h00, alu_result};
                    ADR_SEL_RSV: address = w_pc;
                    default:     address = w_pc;
                endcase
            end
            default: begin
                w_state_nxt = V_LO;
            end
        endcase
    end

    program_counter u_pc (
        .clk          (clk),
        .res          (res),
        .rdy          (rdy),
        .i_load       (w_pc_load),
        .i_inc        (w_pc_inc),
        .i_load_value (w_pc_load_value),
        .o_pc         (w_pc)
    );

    assign pc = w_pc;

endmodule
